// File: rtl/mips_pkg.sv
// mips_pkg: types, default widths and helpers shared by the ID/EX operand stage.
//   - ALU op-code constants (AND..SRL) as driven on alu_operation.
//   - Default DATA_WIDTH / REG_ADDR_WIDTH values for the stage parameters.
//   - extend_imm16(): 16-bit immediate sign/zero extension.
package mips_pkg;

    localparam int unsigned DEF_DATA_WIDTH     = 32;
    localparam int unsigned DEF_REG_ADDR_WIDTH = 5;
    localparam int unsigned OP_WIDTH           = 4;
    localparam int unsigned IMM_WIDTH          = 16;
    localparam int unsigned SHAMT_WIDTH        = 5;

    localparam logic [OP_WIDTH-1:0] ALU_AND = 4'd0;
    localparam logic [OP_WIDTH-1:0] ALU_OR  = 4'd1;
    localparam logic [OP_WIDTH-1:0] ALU_NOR = 4'd2;
    localparam logic [OP_WIDTH-1:0] ALU_ADD = 4'd3;
    localparam logic [OP_WIDTH-1:0] ALU_SUB = 4'd4;
    localparam logic [OP_WIDTH-1:0] ALU_LUI = 4'd5;
    localparam logic [OP_WIDTH-1:0] ALU_SLL = 4'd6;
    localparam logic [OP_WIDTH-1:0] ALU_SRL = 4'd7;

    // Extend a 16-bit immediate to the default data width.
    function automatic logic [DEF_DATA_WIDTH-1:0] extend_imm16(
        input logic [IMM_WIDTH-1:0] imm,
        input logic                 sext
    );
        if (sext) begin
            return {{(DEF_DATA_WIDTH-IMM_WIDTH){imm[IMM_WIDTH-1]}}, imm};
        end
        return {{(DEF_DATA_WIDTH-IMM_WIDTH){1'b0}}, imm};
    endfunction

endpackage

// File: rtl/operand_forward_mux.sv
// operand_forward_mux: selects the freshest value of one source register.
//   src_addr/src_data        registered source index and register-file data
//   exmem_* / memwb_*        downstream writers (EX/MEM has priority)
//   fwd_data_c               forwarded operand (combinational)
// Config macro: OPERAND_FORWARDING_EN. When undefined the mux passes
// src_data through and the forwarding inputs are ignored.
module operand_forward_mux
    import mips_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int unsigned REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH
) (
    input  logic [REG_ADDR_WIDTH-1:0] src_addr,
    input  logic [DATA_WIDTH-1:0]     src_data,
    input  logic                      exmem_reg_write,
    input  logic [REG_ADDR_WIDTH-1:0] exmem_rd_addr,
    input  logic [DATA_WIDTH-1:0]     exmem_result,
    input  logic                      memwb_reg_write,
    input  logic [REG_ADDR_WIDTH-1:0] memwb_rd_addr,
    input  logic [DATA_WIDTH-1:0]     memwb_result,
    output logic [DATA_WIDTH-1:0]     fwd_data_c
);

`ifdef OPERAND_FORWARDING_EN
    // $0 is hard-wired to zero, so it never takes a forwarded value.
    always_comb begin
        fwd_data_c = src_data;
        if (exmem_reg_write && (exmem_rd_addr == src_addr) && (src_addr != '0)) begin
            fwd_data_c = exmem_result;
        end else if (memwb_reg_write && (memwb_rd_addr == src_addr) && (src_addr != '0)) begin
            fwd_data_c = memwb_result;
        end
    end
`else
    // Hazards are resolved upstream by stalling; forwarding inputs are sunk.
    assign fwd_data_c = src_data;

    logic fwd_unused;
    assign fwd_unused = ^{src_addr, exmem_reg_write, exmem_rd_addr, exmem_result,
                          memwb_reg_write, memwb_rd_addr, memwb_result};
`endif

endmodule

// File: rtl/alu_operand_stage.sv
// alu_operand_stage: ID/EX pipeline register plus ALU operand resolution.
//   clk, reset (sync, active-low), stall (hold), flush (bubble)
//   id_*        decoded instruction fields from ID
//   exmem_*/memwb_*  forwarding sources
//   ex_valid, alu_operation, alu_a, alu_b, ex_rd_addr, ex_reg_write  to EX
// Config macro: OPERAND_FORWARDING_EN enables EX/MEM and MEM/WB forwarding.
// Update priority per edge: reset > flush > stall > load.
module alu_operand_stage
    import mips_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int unsigned REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      stall,
    input  logic                      flush,
    input  logic                      id_valid,
    input  logic [OP_WIDTH-1:0]       id_alu_op,
    input  logic [DATA_WIDTH-1:0]     id_rs_data,
    input  logic [DATA_WIDTH-1:0]     id_rt_data,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs_addr,
    input  logic [REG_ADDR_WIDTH-1:0] id_rt_addr,
    input  logic [REG_ADDR_WIDTH-1:0] id_rd_addr,
    input  logic [IMM_WIDTH-1:0]      id_imm16,
    input  logic [SHAMT_WIDTH-1:0]    id_shamt,
    input  logic                      id_alu_src,
    input  logic                      id_imm_sext,
    input  logic                      id_reg_write,
    input  logic                      exmem_reg_write,
    input  logic [REG_ADDR_WIDTH-1:0] exmem_rd_addr,
    input  logic [DATA_WIDTH-1:0]     exmem_result,
    input  logic                      memwb_reg_write,
    input  logic [REG_ADDR_WIDTH-1:0] memwb_rd_addr,
    input  logic [DATA_WIDTH-1:0]     memwb_result,
    output logic                      ex_valid,
    output logic [OP_WIDTH-1:0]       alu_operation,
    output logic [DATA_WIDTH-1:0]     alu_a,
    output logic [DATA_WIDTH-1:0]     alu_b,
    output logic [REG_ADDR_WIDTH-1:0] ex_rd_addr,
    output logic                      ex_reg_write
);

    logic                      valid_q,     valid_d;
    logic [OP_WIDTH-1:0]       op_q,        op_d;
    logic [DATA_WIDTH-1:0]     rs_data_q,   rs_data_d;
    logic [DATA_WIDTH-1:0]     rt_data_q,   rt_data_d;
    logic [REG_ADDR_WIDTH-1:0] rs_addr_q,   rs_addr_d;
    logic [REG_ADDR_WIDTH-1:0] rt_addr_q,   rt_addr_d;
    logic [REG_ADDR_WIDTH-1:0] rd_addr_q,   rd_addr_d;
    logic [IMM_WIDTH-1:0]      imm16_q,     imm16_d;
    logic [SHAMT_WIDTH-1:0]    shamt_q,     shamt_d;
    logic                      alu_src_q,   alu_src_d;
    logic                      imm_sext_q,  imm_sext_d;
    logic                      reg_write_q, reg_write_d;

    // Next-state: flush clears, stall holds, otherwise load from ID.
    always_comb begin
        valid_d     = valid_q;
        op_d        = op_q;
        rs_data_d   = rs_data_q;
        rt_data_d   = rt_data_q;
        rs_addr_d   = rs_addr_q;
        rt_addr_d   = rt_addr_q;
        rd_addr_d   = rd_addr_q;
        imm16_d     = imm16_q;
        shamt_d     = shamt_q;
        alu_src_d   = alu_src_q;
        imm_sext_d  = imm_sext_q;
        reg_write_d = reg_write_q;
        if (flush) begin
            valid_d     = 1'b0;
            op_d        = '0;
            rs_data_d   = '0;
            rt_data_d   = '0;
            rs_addr_d   = '0;
            rt_addr_d   = '0;
            rd_addr_d   = '0;
            imm16_d     = '0;
            shamt_d     = '0;
            alu_src_d   = 1'b0;
            imm_sext_d  = 1'b0;
            reg_write_d = 1'b0;
        end else if (!stall) begin
            // A non-valid ID slot becomes a bubble that can never write back.
            valid_d     = id_valid;
            op_d        = id_alu_op;
            rs_data_d   = id_rs_data;
            rt_data_d   = id_rt_data;
            rs_addr_d   = id_rs_addr;
            rt_addr_d   = id_rt_addr;
            rd_addr_d   = id_rd_addr;
            imm16_d     = id_imm16;
            shamt_d     = id_shamt;
            alu_src_d   = id_alu_src;
            imm_sext_d  = id_imm_sext;
            reg_write_d = id_reg_write & id_valid;
        end
    end

    // ID/EX register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q     <= 1'b0;
            op_q        <= '0;
            rs_data_q   <= '0;
            rt_data_q   <= '0;
            rs_addr_q   <= '0;
            rt_addr_q   <= '0;
            rd_addr_q   <= '0;
            imm16_q     <= '0;
            shamt_q     <= '0;
            alu_src_q   <= 1'b0;
            imm_sext_q  <= 1'b0;
            reg_write_q <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            op_q        <= op_d;
            rs_data_q   <= rs_data_d;
            rt_data_q   <= rt_data_d;
            rs_addr_q   <= rs_addr_d;
            rt_addr_q   <= rt_addr_d;
            rd_addr_q   <= rd_addr_d;
            imm16_q     <= imm16_d;
            shamt_q     <= shamt_d;
            alu_src_q   <= alu_src_d;
            imm_sext_q  <= imm_sext_d;
            reg_write_q <= reg_write_d;
        end
    end

    logic [DATA_WIDTH-1:0] rs_fwd_c;
    logic [DATA_WIDTH-1:0] rt_fwd_c;

    operand_forward_mux #(
        .DATA_WIDTH     (DATA_WIDTH),
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
    ) u_rs_fwd (
        .src_addr        (rs_addr_q),
        .src_data        (rs_data_q),
        .exmem_reg_write (exmem_reg_write),
        .exmem_rd_addr   (exmem_rd_addr),
        .exmem_result    (exmem_result),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd_addr   (memwb_rd_addr),
        .memwb_result    (memwb_result),
        .fwd_data_c      (rs_fwd_c)
    );

    operand_forward_mux #(
        .DATA_WIDTH     (DATA_WIDTH),
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
    ) u_rt_fwd (
        .src_addr        (rt_addr_q),
        .src_data        (rt_data_q),
        .exmem_reg_write (exmem_reg_write),
        .exmem_rd_addr   (exmem_rd_addr),
        .exmem_result    (exmem_result),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd_addr   (memwb_rd_addr),
        .memwb_result    (memwb_result),
        .fwd_data_c      (rt_fwd_c)
    );

    logic                  is_shift_c;
    logic [DATA_WIDTH-1:0] imm_ext_c;

    assign is_shift_c = (op_q == ALU_SLL) || (op_q == ALU_SRL);
    assign imm_ext_c  = DATA_WIDTH'(extend_imm16(imm16_q, imm_sext_q));

    // Operand routing: shifts take rt on A and shamt on B; LUI beats alu_src.
    always_comb begin
        alu_a = is_shift_c ? rt_fwd_c : rs_fwd_c;
        alu_b = rt_fwd_c;
        if (is_shift_c) begin
            alu_b = DATA_WIDTH'(shamt_q);
        end else if (op_q == ALU_LUI) begin
            alu_b = DATA_WIDTH'(imm16_q);
        end else if (alu_src_q) begin
            alu_b = imm_ext_c;
        end
    end

    assign ex_valid      = valid_q;
    assign alu_operation = valid_q ? op_q : '0;
    assign ex_rd_addr    = rd_addr_q;
    assign ex_reg_write  = reg_write_q & valid_q;

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- ID/EX pipeline stage that sits directly upstream of the EX-stage ALU.
- Registers the decoded instruction fields from ID and resolves the ALU operands.
- Drives the ALU's 4-bit operation code and its 32-bit A and B inputs.
- Applies operand forwarding from the EX/MEM and MEM/WB stages, and supports stall (hold) and flush (bubble insertion).

Parameters:
- DATA_WIDTH, 32, width of operands and results.
- REG_ADDR_WIDTH, 5, register-file address width.

Ports:
- clk  in  1  pipeline clock; all state changes on rising edge.
- reset  in  1  synchronous, active-low reset (sampled on rising clk edge).
- stall  in  1  hold all registered fields this cycle.
- flush  in  1  load a bubble this cycle.
- id_valid  in  1  ID holds a real instruction.
- id_alu_op  in  4  ALU op code: AND=0, OR=1, NOR=2, ADD=3, SUB=4, LUI=5, SLL=6, SRL=7.
- id_rs_data  in  DATA_WIDTH  register-file read data for rs.
- id_rt_data  in  DATA_WIDTH  register-file read data for rt.
- id_rs_addr  in  REG_ADDR_WIDTH  rs index.
- id_rt_addr  in  REG_ADDR_WIDTH  rt index.
- id_rd_addr  in  REG_ADDR_WIDTH  destination index, already muxed rd/rt.
- id_imm16  in  16  instruction immediate.
- id_shamt  in  5  shift amount.
- id_alu_src  in  1  1: B is the extended immediate.
- id_imm_sext  in  1  1: sign-extend the immediate; 0: zero-extend.
- id_reg_write  in  1  instruction writes the register file.
- exmem_reg_write  in  1  EX/MEM stage will write a register.
- exmem_rd_addr  in  REG_ADDR_WIDTH  EX/MEM destination index.
- exmem_result  in  DATA_WIDTH  EX/MEM ALU result.
- memwb_reg_write  in  1  MEM/WB stage will write a register.
- memwb_rd_addr  in  REG_ADDR_WIDTH  MEM/WB destination index.
- memwb_result  in  DATA_WIDTH  MEM/WB writeback value.
- ex_valid  out  1  EX stage holds a real instruction.
- alu_operation  out  4  to ALU operation input.
- alu_a  out  DATA_WIDTH  to ALU A input.
- alu_b  out  DATA_WIDTH  to ALU B input.
- ex_rd_addr  out  REG_ADDR_WIDTH  destination index, forwarded downstream.
- ex_reg_write  out  1  write enable, qualified by ex_valid.

Behaviour:
- Register update priority per rising edge: reset==0 > flush > stall > load.
- Reset and flush:
  - All registered fields are cleared: valid=0, op=0, data=0, addresses=0, imm=0, shamt=0, ctrl=0.
  - Consequence: ex_valid=0, ex_reg_write=0, alu_operation=0, alu_a=0, alu_b=0, ex_rd_addr=0.
- Stall: all registers hold their values. Outputs may still change, because forwarding inputs can change.
- flush and stall asserted together: flush wins.
- Load: captures all id_* fields. If id_valid=0, captures a bubble with valid=0 and reg_write=0.
- Latency: one cycle from ID inputs to registered fields. Operand muxing and forwarding are combinational from registered fields plus the current forwarding inputs.
- Forwarded source value (fwd(src_addr, src_data)):
  - exmem_result if exmem_reg_write && exmem_rd_addr==src_addr && src_addr!=0.
  - Else memwb_result if the same conditions hold for memwb.
  - Else registered src_data.
  - EX/MEM has priority when both stages match. Register $0 is never forwarded.
- alu_a:
  - op SLL/SRL: fwd(rt).
  - Otherwise: fwd(rs).
- alu_b:
  - op SLL/SRL: {27'b0, shamt}.
  - Else op LUI: {16'b0, imm16}.
  - Else alu_src=1: imm16 sign- or zero-extended per imm_sext.
  - Else: fwd(rt).
- alu_operation: registered op when valid=1; 0 when valid=0.
- ex_reg_write: registered reg_write && valid.
- Undefined op codes 8–15 are passed through unchanged; the ALU returns 0 for them.

Optional Feature:
- Macro: OPERAND_FORWARDING_EN.
- Defined: forwarding exactly as specified above.
- Undefined:
  - fwd() always returns the registered register-file data.
  - The exmem_* and memwb_* inputs are ignored.
  - Hazards are resolved externally by stalls.
  - Port list is unchanged.

Decomposition:
- Shared package mips_pkg holds:
  - ALU op-code localparams (AND..SRL).
  - DATA_WIDTH and REG_ADDR_WIDTH defaults.
  - The immediate-extension function.
- One sub-module, operand_forward_mux:
  - Combinational src_addr/src_data plus two forwarding sources, producing the forwarded value.
  - Instantiated twice, for rs and rt.

Test Plan:
- Reset and flush: hold reset=0 for 2 cycles with id inputs nonzero -> all outputs 0. Then load ADD rs=0x5, rt=0xA, id_valid=1 and assert flush -> next cycle ex_valid=0, alu_operation=0, alu_a=0, alu_b=0.
- ADDI with sign extension: id_alu_op=3, rs_data=0x10, imm16=0xFFFF, alu_src=1, imm_sext=1 -> alu_a=0x10, alu_b=0xFFFFFFFF, ex_reg_write=1.
- Shift and LUI operand routing:
  - SLL with rt_data=0x1, shamt=4 -> alu_a=0x1, alu_b=0x4.
  - LUI with imm16=0x1234 -> alu_b=0x00001234.
- Forwarding priority:
  - rs_addr=8, exmem(8, 0xAAAA, we=1), memwb(8, 0xBBBB, we=1) -> alu_a=0xAAAA.
  - Then exmem we=0 -> alu_a=0xBBBB.
  - rs_addr=0 with both stages matching -> alu_a equals the registered rs_data.
- Stall hold: load SUB, then stall=1 for 3 cycles while id inputs change -> alu_operation stays 4 and the registered operands are unchanged. stall and flush together -> bubble.
- Feature off (OPERAND_FORWARDING_EN undefined): the forwarding-priority scenario repeated -> alu_a equals the registered rs_data in every case.
